// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue.
// Optional same-cycle bypass on an empty queue: FETCHQ_BYPASS_EN.
package fetch_queue_pkg;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam int          FQ_DEPTH = 4;
    localparam int          ENTRY_W  = 64;

    localparam int INSTR_HI = 63;
    localparam int INSTR_LO = 32;
    localparam int PC4_HI   = 31;
    localparam int PC4_LO   = 0;

    // instr occupies [INSTR_HI:INSTR_LO], pc4 occupies [PC4_HI:PC4_LO]
    typedef struct packed {
        logic [INSTR_HI-INSTR_LO:0] instr;
        logic [PC4_HI-PC4_LO:0]     pc4;
    } fq_entry_t;

endpackage

// File: rtl/fq_ram.sv
// Entry storage for the fetch queue.
// One synchronous write port, one asynchronous read port.
module fq_ram
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  fq_entry_t       wdata,
    input  logic [AW-1:0]   raddr,
    output fq_entry_t       rdata
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Prefetch queue between fetch and decode; flushed on redirect.
// Define FETCHQ_BYPASS_EN for a zero-latency path on an empty queue.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int DEPTH = FQ_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc4,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc4,
    output logic [AW:0]   count
);

    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        byp;
    fq_entry_t   head;
    fq_entry_t   wdata;

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0])
                && (rd_ptr[AW] != wr_ptr[AW]);

    assign in_ready = ~full;

`ifdef FETCHQ_BYPASS_EN
    assign byp = empty & in_valid & ~flush;
`else
    assign byp = 1'b0;
`endif

    // A bypassed word that decode takes right away is never stored
    assign push = in_valid & in_ready & ~flush & ~(byp & out_ready);
    assign pop  = ~empty & out_ready & ~flush;

    assign wdata.instr = in_instr;
    assign wdata.pc4   = in_pc4;

    fq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    always_comb begin
        out_valid = ~empty | byp;
        out_instr = NOP;
        out_pc4   = '0;
        if (byp) begin
            out_instr = in_instr;
            out_pc4   = in_pc4;
        end else if (!empty) begin
            out_instr = head.instr;
            out_pc4   = head.pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue.
// Rows marked byp see the input word on out_* when FETCHQ_BYPASS_EN is set.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc4   (out_pc4),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        fl;
        logic        ordy;
        logic        byp;
        logic        ov;
        logic        ir;
        logic [2:0]  cnt;
        logic [31:0] oi;
        logic [31:0] op;
    } vec_t;

    vec_t vecs [31];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(
        logic r, logic iv, logic [31:0] ins, logic [31:0] p,
        logic fl, logic ordy, logic byp,
        logic ov, logic ir, logic [2:0] c,
        logic [31:0] oi, logic [31:0] op);
        vec_t v;
        v.rst = r;  v.iv = iv; v.instr = ins; v.pc4 = p;
        v.fl = fl;  v.ordy = ordy; v.byp = byp;
        v.ov = ov;  v.ir = ir; v.cnt = c; v.oi = oi; v.op = op;
        return v;
    endfunction

    localparam logic [31:0] A = 32'h2008_0001;
    localparam logic [31:0] B = 32'h2009_0002;
    localparam logic [31:0] C = 32'h200A_0003;
    localparam logic [31:0] D = 32'h200B_0004;
    localparam logic [31:0] E = 32'h200C_0005;
    localparam logic [31:0] F = 32'h8C01_0000;
    localparam logic [31:0] G = 32'h8C02_0004;
    localparam logic [31:0] H = 32'h1111_0001;
    localparam logic [31:0] I = 32'h2222_0002;
    localparam logic [31:0] J = 32'h3333_0003;
    localparam logic [31:0] K = 32'h4444_0004;
    localparam logic [31:0] L = 32'h5555_0005;
    localparam logic [31:0] M = 32'h6666_0006;
    localparam logic [31:0] N = 32'h7777_0007;
    localparam logic [31:0] O = 32'h7878_0008;

    initial begin
        vec_t v;
        logic        e_ov;
        logic [31:0] e_oi;
        logic [31:0] e_op;

        // rst iv instr pc4 fl ordy byp | ov ir cnt oi op
        vecs[0]  = mk(0,0,0,0,0,0,0, 0,1,0,0,0);
        vecs[1]  = mk(0,1,A,32'h04,0,0,1, 0,1,0,0,0);
        vecs[2]  = mk(0,1,B,32'h08,0,0,0, 1,1,1,A,32'h04);
        vecs[3]  = mk(0,1,C,32'h0C,0,0,0, 1,1,2,A,32'h04);
        vecs[4]  = mk(0,1,D,32'h10,0,0,0, 1,1,3,A,32'h04);
        vecs[5]  = mk(0,1,E,32'h14,0,0,0, 1,0,4,A,32'h04);
        vecs[6]  = mk(0,0,0,0,0,0,0, 1,0,4,A,32'h04);
        vecs[7]  = mk(0,0,0,0,0,1,0, 1,0,4,A,32'h04);
        vecs[8]  = mk(0,1,F,32'h100,0,1,0, 1,1,3,B,32'h08);
        vecs[9]  = mk(0,1,G,32'h104,0,0,0, 1,1,3,C,32'h0C);
        vecs[10] = mk(0,0,0,0,0,1,0, 1,0,4,C,32'h0C);
        vecs[11] = mk(0,0,0,0,0,1,0, 1,1,3,D,32'h10);
        vecs[12] = mk(0,0,0,0,0,1,0, 1,1,2,F,32'h100);
        vecs[13] = mk(0,0,0,0,0,1,0, 1,1,1,G,32'h104);
        vecs[14] = mk(0,0,0,0,0,0,0, 0,1,0,0,0);
        vecs[15] = mk(0,1,H,32'h200,0,0,1, 0,1,0,0,0);
        vecs[16] = mk(0,1,I,32'h204,0,0,0, 1,1,1,H,32'h200);
        vecs[17] = mk(0,1,J,32'h208,0,1,0, 1,1,2,H,32'h200);
        vecs[18] = mk(0,0,0,0,0,0,0, 1,1,2,I,32'h204);
        vecs[19] = mk(0,0,0,0,0,1,0, 1,1,2,I,32'h204);
        vecs[20] = mk(0,0,0,0,0,1,0, 1,1,1,J,32'h208);
        vecs[21] = mk(0,0,0,0,0,0,0, 0,1,0,0,0);
        vecs[22] = mk(0,1,K,32'h300,0,0,1, 0,1,0,0,0);
        vecs[23] = mk(0,1,L,32'h304,0,0,0, 1,1,1,K,32'h300);
        vecs[24] = mk(0,1,M,32'h308,0,0,0, 1,1,2,K,32'h300);
        vecs[25] = mk(0,1,32'hFFFF_FFFF,32'hFFFF_FFFC,1,1,0,
                      1,1,3,K,32'h300);
        vecs[26] = mk(0,0,0,0,0,1,0, 0,1,0,0,0);
        vecs[27] = mk(0,1,N,32'h400,0,0,1, 0,1,0,0,0);
        vecs[28] = mk(0,1,O,32'h404,0,0,0, 1,1,1,N,32'h400);
        vecs[29] = mk(1,1,O,32'h404,0,0,0, 1,1,2,N,32'h400);
        vecs[30] = mk(0,0,0,0,0,1,0, 0,1,0,0,0);

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc4 = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 31; i++) begin
            v = vecs[i];
            @(negedge clk);
            rst = v.rst; in_valid = v.iv; in_instr = v.instr;
            in_pc4 = v.pc4; flush = v.fl; out_ready = v.ordy;
            #1;
            e_ov = v.ov; e_oi = v.oi; e_op = v.op;
`ifdef FETCHQ_BYPASS_EN
            if (v.byp) begin
                e_ov = 1'b1; e_oi = v.instr; e_op = v.pc4;
            end
`endif
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(e_ov));
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(v.ir));
            check($sformatf("v%0d count", i), 32'(count), 32'(v.cnt));
            check($sformatf("v%0d out_instr", i), out_instr, e_oi);
            check($sformatf("v%0d out_pc4", i), out_pc4, e_op);
        end

        // Empty queue, word offered with decode ready
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1;
        in_instr = 32'h03E0_0008; in_pc4 = 32'h24; out_ready = 1'b1;
        #1;
`ifdef FETCHQ_BYPASS_EN
        check("byp same-cycle valid", 32'(out_valid), 32'd1);
        check("byp same-cycle instr", out_instr, 32'h03E0_0008);
        check("byp same-cycle pc4", out_pc4, 32'h24);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("byp next count", 32'(count), 32'd0);
        check("byp next valid", 32'(out_valid), 32'd0);
`else
        check("nobyp same-cycle valid", 32'(out_valid), 32'd0);
        check("nobyp same-cycle instr", out_instr, 32'h0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("nobyp next valid", 32'(out_valid), 32'd1);
        check("nobyp next instr", out_instr, 32'h03E0_0008);
        check("nobyp next count", 32'(count), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("nobyp drained", 32'(count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
